// File: rtl/apb_multi_slave_subsys.sv
// apb_multi_slave_subsys
// Request front end (valid/ready) driving an APB master FSM (IDLE/SETUP/ACCESS)
// that fans out to NUM_SLAVES register-file slaves. Addresses past the last
// slave are answered by an internal error responder (PSLVERR, no commit).
// Optional build macro: APB_PSTRB_EN adds req_strb/apb_pstrb byte-lane writes.
module apb_multi_slave_subsys #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_DEPTH   = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    apb_clk,
  input  logic                    apb_reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr_rd,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic [DATA_WIDTH/8-1:0] apb_pstrb,
`endif
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_SLAVES-1:0]   apb_psel,
  output logic                    apb_penable,
  output logic                    apb_pwrite,
  output logic [ADDR_WIDTH-1:0]   apb_paddr,
  output logic                    apb_pready
);

  localparam int OFF_W = $clog2(SLV_DEPTH);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_SLAVES_A = ADDR_WIDTH'(NUM_SLAVES);
  localparam logic [3:0]            WAIT_L       = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t                  r_state;
  logic                    r_req_ready;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_unmapped;
  logic [3:0]              r_wait_cnt;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] r_pstrb;
`endif

  // Slave register files, one row per slave.
  logic [DATA_WIDTH-1:0]   r_mem [NUM_SLAVES][SLV_DEPTH];

  // Decode of the incoming request address (used only at accept).
  logic [ADDR_WIDTH-1:0]   w_req_slot;
  logic                    w_req_mapped;
  logic [NUM_SLAVES-1:0]   w_req_psel;

  assign w_req_slot   = req_addr >> OFF_W;
  assign w_req_mapped = (w_req_slot < NUM_SLAVES_A);
  assign w_req_psel   = w_req_mapped ? (NUM_SLAVES'(1) << w_req_slot[IDX_W-1:0])
                                     : '0;

  // Decode of the transfer in flight (from the registered address).
  logic [IDX_W-1:0]        w_slv_idx;
  logic [OFF_W-1:0]        w_offset;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic                    w_pready;
  logic                    w_commit;

  assign w_slv_idx = r_paddr[OFF_W +: IDX_W];
  assign w_offset  = r_paddr[OFF_W-1:0];
  assign w_rd_word = r_mem[w_slv_idx][w_offset];

  // The error responder answers in the first ACCESS cycle; a mapped slave
  // answers once its wait counter has reached WAIT_CYCLES.
  assign w_pready = (r_state == ST_ACCESS) && (r_unmapped || (r_wait_cnt == WAIT_L));
  assign w_commit = w_pready && r_pwrite && !r_unmapped;

  // Master FSM: request capture, APB phase sequencing and response pulse.
  // NOTE: all state here is updated with <= so every branch sees the values
  // from before the clock edge, exactly like the flops it describes.
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_wdata     <= '0;
      r_unmapped  <= 1'b0;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_PSTRB_EN
      r_pstrb     <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_state     <= ST_SETUP;
            r_req_ready <= 1'b0;
            r_pwrite    <= req_wr_rd;
            r_paddr     <= req_addr;
            r_wdata     <= req_wdata;
            r_psel      <= w_req_psel;
            r_unmapped  <= !w_req_mapped;
`ifdef APB_PSTRB_EN
            r_pstrb     <= req_strb;
`endif
          end
        end
        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (w_pready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_penable   <= 1'b0;
            r_psel      <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_unmapped;
            r_rsp_rdata <= (!r_pwrite && !r_unmapped) ? w_rd_word : '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Slave storage: cleared by reset, written on the completing edge only.
  // NOTE: the memory has an explicit reset loop because slaves must read 0
  // after reset; this makes it flops rather than an inferable RAM.
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        for (int w = 0; w < SLV_DEPTH; w++) begin
          r_mem[s][w] <= '0;
        end
      end
    end else if (w_commit) begin
`ifdef APB_PSTRB_EN
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (r_pstrb[b]) begin
          r_mem[w_slv_idx][w_offset][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
`else
      r_mem[w_slv_idx][w_offset] <= r_wdata;
`endif
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign apb_psel    = r_psel;
  assign apb_penable = r_penable;
  assign apb_pwrite  = r_pwrite;
  assign apb_paddr   = r_paddr;
  assign apb_pready  = w_pready;
`ifdef APB_PSTRB_EN
  assign apb_pstrb   = r_pstrb;
`endif

endmodule

// File: tb/tb_apb_multi_slave_subsys.sv
// Directed bench for apb_multi_slave_subsys: one instance with WAIT_CYCLES=0
// for the functional sequence and one with WAIT_CYCLES=3 for wait states.
module tb_apb_multi_slave_subsys;

  logic        clk = 1'b0;
  logic        apb_reset;

  // Instance A (WAIT_CYCLES = 0)
  logic        req_valid, req_ready, req_wr_rd;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  apb_psel;
  logic        apb_penable, apb_pwrite, apb_pready;
  logic [9:0]  apb_paddr;

  // Instance B (WAIT_CYCLES = 3)
  logic        b_valid, b_ready, b_wr_rd;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_strb;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [3:0]  b_psel;
  logic        b_penable, b_pwrite, b_pready;
  logic [9:0]  b_paddr;

`ifdef APB_PSTRB_EN
  logic [3:0]  apb_pstrb, b_pstrb;
`endif

  int checks = 0;
  int errors = 0;

  // Results captured by xfer()
  logic [31:0] t_rd;
  logic        t_err, t_ok, t_rdy, t_after, t_pwrite, t_pen_setup;
  logic [3:0]  t_psel;
  logic [9:0]  t_paddr;
  int          t_lat;

  always #5 clk = ~clk;

  apb_multi_slave_subsys #(.WAIT_CYCLES(0)) dut_a (
    .apb_clk(clk), .apb_reset(apb_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr_rd(req_wr_rd),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef APB_PSTRB_EN
    .req_strb(req_strb), .apb_pstrb(apb_pstrb),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pready(apb_pready)
  );

  apb_multi_slave_subsys #(.WAIT_CYCLES(3)) dut_b (
    .apb_clk(clk), .apb_reset(apb_reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_wr_rd(b_wr_rd),
    .req_addr(b_addr), .req_wdata(b_wdata),
`ifdef APB_PSTRB_EN
    .req_strb(b_strb), .apb_pstrb(b_pstrb),
`endif
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .apb_psel(b_psel), .apb_penable(b_penable), .apb_pwrite(b_pwrite),
    .apb_paddr(b_paddr), .apb_pready(b_pready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on instance A; latency counted in cycles after the accept edge.
  task automatic xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr_rd = wr; req_addr = addr; req_wdata = wd; req_strb = strb;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    t_lat = 1; t_psel = apb_psel; t_paddr = apb_paddr; t_pwrite = apb_pwrite;
    t_pen_setup = apb_penable;
    while (!rsp_valid && t_lat < 60) begin @(negedge clk); t_lat++; end
    t_ok = rsp_valid; t_rd = rsp_rdata; t_err = rsp_err; t_rdy = req_ready;
    @(negedge clk);
    t_after = rsp_valid;
  endtask

  initial begin
    int          n, lat, pen, prdy, cyc, npulse;
    int          pulse_cyc[$];
    logic [31:0] pulse_dat[$];
    logic        pulse_err[$];
    logic [3:0]  ps;

    apb_reset = 1'b1;
    req_valid = 1'b0; req_wr_rd = 1'b0; req_addr = '0; req_wdata = '0; req_strb = 4'hF;
    b_valid = 1'b0; b_wr_rd = 1'b0; b_addr = '0; b_wdata = '0; b_strb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values (sampled while reset is still held)
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_psel",      apb_psel, 0);
    check("rst_penable",   apb_penable, 0);
    check("rst_pwrite",    apb_pwrite, 0);
    check("rst_paddr",     apb_paddr, 0);
    check("rst_pready",    apb_pready, 0);
    apb_reset = 1'b0;

    // Read addr 0 after reset
    xfer(1'b0, 10'd0, 32'h0, 4'hF);
    check("rd0_seen",      t_ok, 1);
    check("rd0_latency",   t_lat, 3);
    check("rd0_rdata",     t_rd, 0);
    check("rd0_err",       t_err, 0);
    check("rd0_psel",      t_psel, 4'b0001);
    check("rd0_ready_rsp", t_rdy, 1);
    check("rd0_one_pulse", t_after, 0);

    // Write 0xDEADBEEF to 70, read it back (slave 1)
    xfer(1'b1, 10'd70, 32'hDEADBEEF, 4'hF);
    check("wr70_seen",    t_ok, 1);
    check("wr70_psel",    t_psel, 4'b0010);
    check("wr70_paddr",   t_paddr, 10'd70);
    check("wr70_pwrite",  t_pwrite, 1);
    check("wr70_pen_set", t_pen_setup, 0);
    check("wr70_rdata",   t_rd, 0);
    check("wr70_err",     t_err, 0);
    xfer(1'b0, 10'd70, 32'h0, 4'hF);
    check("rd70_psel",    t_psel, 4'b0010);
    check("rd70_rdata",   t_rd, 32'hDEADBEEF);
    check("rd70_err",     t_err, 0);

    // Unmapped address 300 (slot 4): error, no commit, no aliasing onto 44
    xfer(1'b1, 10'd300, 32'h12345678, 4'hF);
    check("wr300_psel",    t_psel, 0);
    check("wr300_err",     t_err, 1);
    check("wr300_latency", t_lat, 3);
    xfer(1'b0, 10'd300, 32'h0, 4'hF);
    check("rd300_psel",  t_psel, 0);
    check("rd300_err",   t_err, 1);
    check("rd300_rdata", t_rd, 0);
    xfer(1'b0, 10'd44, 32'h0, 4'hF);
    check("rd44_rdata",  t_rd, 0);
    check("rd44_err",    t_err, 0);

    // Back-to-back: valid held across 4 writes then 4 reads
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          req_valid = 1'b1;
          req_wr_rd = (i < 4);
          req_addr  = 10'(i % 4);
          req_wdata = 32'hA5A5_0000 + 32'(i);
          req_strb  = 4'hF;
          n = 0;
          @(negedge clk);
          while (!req_ready && n < 20) begin @(negedge clk); n++; end
          @(posedge clk); #1;
        end
        req_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            pulse_cyc.push_back(c);
            pulse_dat.push_back(rsp_rdata);
            pulse_err.push_back(rsp_err);
          end
        end
      end
    join
    npulse = pulse_cyc.size();
    check("b2b_count", npulse, 8);
    if (npulse == 8) begin
      for (int i = 1; i < 8; i++)
        check($sformatf("b2b_spacing_%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 3);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b_wr_rdata_%0d", i), pulse_dat[i], 0);
        check($sformatf("b2b_rd_rdata_%0d", i), pulse_dat[4+i], 32'hA5A5_0000 + 32'(i));
        check($sformatf("b2b_rd_err_%0d", i), pulse_err[4+i], 0);
      end
    end

    // Reset asserted in the ACCESS cycle of a write to addr 5
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr_rd = 1'b1; req_addr = 10'd5; req_wdata = 32'h5555_AAAA;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_access", apb_penable, 1);
    check("abort_pready",    apb_pready, 1);
    apb_reset = 1'b1;
    @(negedge clk);
    apb_reset = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_penable",   apb_penable, 0);
    check("abort_psel",      apb_psel, 0);
    npulse = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid) npulse++;
      @(negedge clk);
    end
    check("abort_no_rsp", npulse, 0);
    xfer(1'b0, 10'd5, 32'h0, 4'hF);
    check("abort_rd5", t_rd, 0);
    xfer(1'b0, 10'd70, 32'h0, 4'hF);
    check("abort_rd70_cleared", t_rd, 0);

    // Wait states on instance B: write addr 200 (slave 3)
    @(posedge clk); #1;
    b_valid = 1'b1; b_wr_rd = 1'b1; b_addr = 10'd200; b_wdata = 32'hCAFE_0003; b_strb = 4'hF;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b_valid = 1'b0;
    lat = 0; pen = 0; prdy = 0; ps = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) ps = b_psel;
      if (b_penable) pen++;
      if (b_pready) prdy++;
    end while (!b_rsp_valid && lat < 60);
    check("wait_latency", lat, 6);
    check("wait_penable_cycles", pen, 4);
    check("wait_pready_cycles", prdy, 1);
    check("wait_psel", ps, 4'b1000);
    check("wait_err", b_rsp_err, 0);

`ifdef APB_PSTRB_EN
    // Byte-lane writes to addr 9
    xfer(1'b1, 10'd9, 32'hFFFFFFFF, 4'hF);
    xfer(1'b1, 10'd9, 32'h00000000, 4'b0101);
    xfer(1'b0, 10'd9, 32'h0, 4'h0);
    check("strb_rd9", t_rd, 32'hFF00FF00);
    xfer(1'b1, 10'd9, 32'h12345678, 4'h0);
    check("strb0_err", t_err, 0);
    xfer(1'b0, 10'd9, 32'h0, 4'hF);
    check("strb0_rd9", t_rd, 32'hFF00FF00);
`endif

    cyc = checks;
    $display("CHECKS %0d ERRORS %0d", cyc, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
